// File: rtl/tomasulo_pkg.sv
// Shared types for the Tomasulo core: tags, CDB, issue payload and the
// reservation-station dispatch record used by tomasulo_rs_mpy.
package tomasulo_pkg;

  localparam int WORD_W       = 32;
  localparam int TAG_W        = 4;
  localparam int RS_N_DEFAULT = 4;

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    logic              vld;
    tag_t              tag;
    logic [WORD_W-1:0] wdata;
  } cdb_t;

  typedef struct packed {
    tag_t              tag;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
  } issue_t;

  typedef struct packed {
    logic              rdy;
    tag_t              tag;
    logic [WORD_W-1:0] data;
  } rs_src_t;

  typedef struct packed {
    tag_t          tag;
    rs_src_t [1:0] src;
  } rs_disp_t;

  typedef enum logic [1:0] {
    RS_EMPTY,
    RS_WAIT,
    RS_READY
  } rs_state_t;

  function automatic logic cdb_hit(rs_src_t s, cdb_t c);
    return !s.rdy && c.vld && (s.tag == c.tag);
  endfunction

  function automatic rs_src_t cdb_capture(rs_src_t s, cdb_t c);
    rs_src_t r;
    r = s;
    if (cdb_hit(s, c)) begin
      r.rdy  = 1'b1;
      r.data = c.wdata;
    end
    return r;
  endfunction

endpackage

// File: rtl/tomasulo_age_matrix.sv
// Age matrix: older_r[i][j] set means entry i was allocated before entry j.
// gnt picks the single oldest valid requester.
module tomasulo_age_matrix #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [N-1:0] alloc,
  input  logic [N-1:0] free,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  logic [N-1:0] vld_r;
  logic [N-1:0] older_r [N];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_r <= '0;
      for (int i = 0; i < N; i++) older_r[i] <= '0;
    end else if (flush) begin
      vld_r <= '0;
      for (int i = 0; i < N; i++) older_r[i] <= '0;
    end else begin
      vld_r <= alloc | (vld_r & ~free);
      // A new entry is younger than every entry still alive this cycle.
      for (int i = 0; i < N; i++) begin
        if (alloc[i]) begin
          older_r[i] <= '0;
        end else begin
          for (int j = 0; j < N; j++) begin
            if (alloc[j]) older_r[i][j] <= vld_r[i] & ~free[i];
          end
        end
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < N; i++) begin
      gnt[i] = req[i] & vld_r[i];
      for (int j = 0; j < N; j++) begin
        if (j != i && req[j] && vld_r[j] && older_r[j][i]) gnt[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/tomasulo_rs_mpy.sv
// Multiplier reservation station: CDB-snooping entries, oldest-ready select,
// registered issue port. TOMASULO_RS_FAST_WAKEUP_EN allows select in the wakeup cycle.
module tomasulo_rs_mpy
  import tomasulo_pkg::*;
#(
  parameter int N = RS_N_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               disp_vld,
  input  rs_disp_t           disp,
  output logic               disp_rdy,
  input  cdb_t               cdb,
  input  logic               flush,
  output logic               iss_vld,
  output issue_t             iss,
  input  logic               iss_rdy,
  output logic [$clog2(N):0] occ_r
);

  localparam int OCC_W = $clog2(N) + 1;

  rs_state_t     state_r [N];
  tag_t          tag_r   [N];
  rs_src_t [1:0] src_r   [N];

  logic [N-1:0] empty_v, req_v, gnt_v, alloc_v, free_v;
  logic         full_r, do_disp, load, sel_any;
  issue_t       sel_iss;

  function automatic logic srcs_ready(rs_src_t [1:0] s, cdb_t c);
    return (s[0].rdy || cdb_hit(s[0], c)) && (s[1].rdy || cdb_hit(s[1], c));
  endfunction

  assign full_r   = (occ_r == OCC_W'(N));
  assign disp_rdy = !full_r;
  assign do_disp  = disp_vld && disp_rdy;
  assign load     = !iss_vld || iss_rdy;
  assign free_v   = load ? gnt_v : '0;
  assign sel_any  = |gnt_v;

  always_comb begin
    empty_v = '0;
    req_v   = '0;
    for (int i = 0; i < N; i++) begin
      empty_v[i] = (state_r[i] == RS_EMPTY);
`ifdef TOMASULO_RS_FAST_WAKEUP_EN
      req_v[i] = (state_r[i] == RS_READY) ||
                 ((state_r[i] == RS_WAIT) && srcs_ready(src_r[i], cdb));
`else
      req_v[i] = (state_r[i] == RS_READY);
`endif
    end
  end

  // Lowest-index empty entry wins allocation.
  always_comb begin
    alloc_v = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (empty_v[i]) begin
        alloc_v    = '0;
        alloc_v[i] = do_disp;
      end
    end
  end

  tomasulo_age_matrix #(.N(N)) u_age (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .alloc (alloc_v),
    .free  (free_v),
    .req   (req_v),
    .gnt   (gnt_v)
  );

  always_comb begin
    sel_iss = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_v[i]) begin
        sel_iss.tag = tag_r[i];
`ifdef TOMASULO_RS_FAST_WAKEUP_EN
        sel_iss.a = src_r[i][0].rdy ? src_r[i][0].data : cdb.wdata;
        sel_iss.b = src_r[i][1].rdy ? src_r[i][1].data : cdb.wdata;
`else
        sel_iss.a = src_r[i][0].data;
        sel_iss.b = src_r[i][1].data;
`endif
      end
    end
  end

  // ---- entry state / occupancy ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) state_r[i] <= RS_EMPTY;
      occ_r <= '0;
    end else if (flush) begin
      for (int i = 0; i < N; i++) state_r[i] <= RS_EMPTY;
      occ_r <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (alloc_v[i]) begin
          state_r[i] <= srcs_ready(disp.src, cdb) ? RS_READY : RS_WAIT;
        end else if (free_v[i]) begin
          state_r[i] <= RS_EMPTY;
        end else if (state_r[i] == RS_WAIT && srcs_ready(src_r[i], cdb)) begin
          state_r[i] <= RS_READY;
        end
      end
      occ_r <= occ_r + OCC_W'(do_disp) - OCC_W'(|free_v);
    end
  end

  // Payload is qualified by state, so it carries no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (alloc_v[i]) begin
        tag_r[i] <= disp.tag;
        for (int k = 0; k < 2; k++) src_r[i][k] <= cdb_capture(disp.src[k], cdb);
      end else if (state_r[i] == RS_WAIT) begin
        for (int k = 0; k < 2; k++) src_r[i][k] <= cdb_capture(src_r[i][k], cdb);
      end
    end
  end

  // ---- issue output register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iss_vld <= 1'b0;
      iss     <= '0;
    end else if (flush) begin
      iss_vld <= 1'b0;
      iss     <= '0;
    end else if (load) begin
      iss_vld <= sel_any;
      if (sel_any) iss <= sel_iss;
    end
  end

endmodule

// File: tb/tb_tomasulo_rs_mpy.sv
// Scoreboard bench for tomasulo_rs_mpy: expected issues queued at dispatch,
// popped and compared on every accepted issue.
module tb_tomasulo_rs_mpy;
  import tomasulo_pkg::*;

  localparam int N = 4;
`ifdef TOMASULO_RS_FAST_WAKEUP_EN
  localparam int FAST = 1;
`else
  localparam int FAST = 0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               disp_vld = 1'b0;
  rs_disp_t           disp = '0;
  logic               disp_rdy;
  cdb_t               cdb = '0;
  logic               flush = 1'b0;
  logic               iss_vld;
  issue_t             iss;
  logic               iss_rdy = 1'b1;
  logic [$clog2(N):0] occ_r;

  int     total = 0;
  int     bad   = 0;
  issue_t sb_q[$];

  always #5 clk = ~clk;

  tomasulo_rs_mpy #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .disp_vld (disp_vld),
    .disp     (disp),
    .disp_rdy (disp_rdy),
    .cdb      (cdb),
    .flush    (flush),
    .iss_vld  (iss_vld),
    .iss      (iss),
    .iss_rdy  (iss_rdy),
    .occ_r    (occ_r)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_vld = 1'b0;
    disp     = '0;
    cdb      = '0;
    flush    = 1'b0;
  endtask

  task automatic set_disp(input tag_t t, input logic r0, input tag_t t0, input logic [31:0] d0,
                          input logic r1, input tag_t t1, input logic [31:0] d1);
    rs_src_t s0, s1;
    s0.rdy = r0; s0.tag = t0; s0.data = d0;
    s1.rdy = r1; s1.tag = t1; s1.data = d1;
    disp_vld    = 1'b1;
    disp.tag    = t;
    disp.src[0] = s0;
    disp.src[1] = s1;
  endtask

  task automatic set_cdb(input tag_t t, input logic [31:0] d);
    cdb.vld   = 1'b1;
    cdb.tag   = t;
    cdb.wdata = d;
  endtask

  task automatic expect_iss(input tag_t t, input logic [31:0] a, input logic [31:0] b);
    issue_t e;
    e.tag = t; e.a = a; e.b = b;
    sb_q.push_back(e);
  endtask

  // Scoreboard: an issue is consumed when iss_vld && iss_rdy at the coming edge.
  always @(negedge clk) begin
    issue_t e;
    if (rst && iss_vld && iss_rdy) begin
      if (sb_q.size() == 0) begin
        check("sb_extra_issue", 64'(sb_q.size()), 64'd1);
      end else begin
        e = sb_q.pop_front();
        check("sb_tag", 64'(iss.tag), 64'(e.tag));
        check("sb_a", 64'(iss.a), 64'(e.a));
        check("sb_b", 64'(iss.b), 64'(e.b));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("rst_iss_vld", 64'(iss_vld), 64'd0);
    check("rst_occ", 64'(occ_r), 64'd0);
    check("rst_disp_rdy", 64'(disp_rdy), 64'd1);
    check("rst_iss_tag", 64'(iss.tag), 64'd0);
    check("rst_iss_a", 64'(iss.a), 64'd0);
    rst = 1'b1;
    tick();

    // Ready dispatch
    set_disp(4'd3, 1'b1, 4'd0, 32'd6, 1'b1, 4'd0, 32'd7);
    expect_iss(4'd3, 32'd6, 32'd7);
    tick(); idle();
    check("t1_occ_c1", 64'(occ_r), 64'd1);
    check("t1_vld_c1", 64'(iss_vld), 64'd0);
    tick();
    check("t1_vld_c2", 64'(iss_vld), 64'd1);
    check("t1_tag", 64'(iss.tag), 64'd3);
    check("t1_a", 64'(iss.a), 64'd6);
    check("t1_b", 64'(iss.b), 64'd7);
    tick();
    check("t1_occ_c3", 64'(occ_r), 64'd0);
    check("t1_vld_c3", 64'(iss_vld), 64'd0);
    tick();

    // CDB wakeup
    set_disp(4'd1, 1'b0, 4'd9, 32'd0, 1'b1, 4'd0, 32'd2);
    expect_iss(4'd1, 32'h55, 32'd2);
    tick(); idle();
    tick(); tick();
    check("t2_wait_c3", 64'(iss_vld), 64'd0);
    check("t2_occ_c3", 64'(occ_r), 64'd1);
    tick();
    set_cdb(4'd9, 32'h55);
    tick(); idle();
    check("t2_vld_c5", 64'(iss_vld), 64'(FAST));
    tick();
    check("t2_vld_c6", 64'(iss_vld), 64'(1 - FAST));
    tick(); tick();
    check("t2_occ_end", 64'(occ_r), 64'd0);

    // Age order and full
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_disp_rdy_%0d", i), 64'(disp_rdy), 64'd1);
      set_disp(tag_t'(i), 1'b0, 4'd8, 32'd0, 1'b1, 4'd0, 32'(i + 10));
      expect_iss(tag_t'(i), 32'h88, 32'(i + 10));
      tick();
    end
    idle();
    check("t3_full_occ", 64'(occ_r), 64'd4);
    check("t3_full_rdy", 64'(disp_rdy), 64'd0);
    set_disp(4'd15, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1);
    set_cdb(4'd8, 32'h88);
    tick(); idle();
    if (FAST == 0) tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_vld_%0d", i), 64'(iss_vld), 64'd1);
      check($sformatf("t3_order_%0d", i), 64'(iss.tag), 64'(i));
      tick();
    end
    check("t3_drained", 64'(iss_vld), 64'd0);
    check("t3_occ_end", 64'(occ_r), 64'd0);

    // Backpressure
    iss_rdy = 1'b0;
    set_disp(4'd4, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd2); expect_iss(4'd4, 32'd1, 32'd2); tick();
    set_disp(4'd5, 1'b1, 4'd0, 32'd3, 1'b1, 4'd0, 32'd4); expect_iss(4'd5, 32'd3, 32'd4); tick();
    set_disp(4'd6, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd6); expect_iss(4'd6, 32'd5, 32'd6); tick();
    idle();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t4_hold_vld_%0d", k), 64'(iss_vld), 64'd1);
      check($sformatf("t4_hold_tag_%0d", k), 64'(iss.tag), 64'd4);
      check($sformatf("t4_hold_a_%0d", k), 64'(iss.a), 64'd1);
      check($sformatf("t4_occ_%0d", k), 64'(occ_r), 64'd2);
      tick();
    end
    iss_rdy = 1'b1;
    check("t4_rel_tag4", 64'(iss.tag), 64'd4);
    tick();
    check("t4_rel_vld5", 64'(iss_vld), 64'd1);
    check("t4_rel_tag5", 64'(iss.tag), 64'd5);
    tick();
    check("t4_rel_vld6", 64'(iss_vld), 64'd1);
    check("t4_rel_tag6", 64'(iss.tag), 64'd6);
    tick();
    check("t4_done", 64'(iss_vld), 64'd0);

    // Dispatch-cycle capture
    set_disp(4'd7, 1'b1, 4'd0, 32'h11, 1'b0, 4'd5, 32'd0);
    set_cdb(4'd5, 32'hAB);
    expect_iss(4'd7, 32'h11, 32'hAB);
    tick(); idle();
    for (int k = 0; k < 10 && !iss_vld; k++) tick();
    check("t5_no_hang", 64'(iss_vld), 64'd1);
    check("t5_b", 64'(iss.b), 64'hAB);
    tick(); tick();

    // Flush
    iss_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_disp(tag_t'(10 + i), 1'b1, 4'd0, 32'(i), 1'b1, 4'd0, 32'(i));
      expect_iss(tag_t'(10 + i), 32'(i), 32'(i));
      tick();
    end
    idle();
    check("t6_occ3", 64'(occ_r), 64'd3);
    check("t6_vld_pre", 64'(iss_vld), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sb_q.delete();
    check("t6_flush_vld", 64'(iss_vld), 64'd0);
    check("t6_flush_occ", 64'(occ_r), 64'd0);
    check("t6_flush_rdy", 64'(disp_rdy), 64'd1);
    iss_rdy = 1'b1;
    tick(); tick();
    check("t6_flush_ghost", 64'(iss_vld), 64'd0);

    // Reset mid-stream
    iss_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_disp(tag_t'(10 + i), 1'b1, 4'd0, 32'(i), 1'b1, 4'd0, 32'(i));
      expect_iss(tag_t'(10 + i), 32'(i), 32'(i));
      tick();
    end
    idle();
    check("t7_occ3", 64'(occ_r), 64'd3);
    check("t7_vld_pre", 64'(iss_vld), 64'd1);
    #2 rst = 1'b0;
    #1;
    sb_q.delete();
    check("t7_rst_vld", 64'(iss_vld), 64'd0);
    check("t7_rst_occ", 64'(occ_r), 64'd0);
    check("t7_rst_rdy", 64'(disp_rdy), 64'd1);
    tick(); tick();
    rst = 1'b1;
    iss_rdy = 1'b1;
    tick(); tick();
    check("t7_rst_ghost", 64'(iss_vld), 64'd0);
    set_disp(4'd2, 1'b1, 4'd0, 32'd9, 1'b1, 4'd0, 32'd9);
    expect_iss(4'd2, 32'd9, 32'd9);
    tick(); idle();
    tick();
    check("t7_post_vld", 64'(iss_vld), 64'd1);
    check("t7_post_tag", 64'(iss.tag), 64'd2);
    tick(); tick();

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
